options_digit_entry: RTL and testbench

- Inverse of the options decimalizer: turns keypad/button decimal digit entry back into a clamped binary option value, such as pins_count, guesses or PIX_W.
- Holds up to MAX_DIGITS entered digits and exposes them for on-screen echo in the options menu.
- On commit, converts the digits MSD-first with one Horner step per cycle, clamps the result to [min_value, max_value] and returns it to the game state machine with a one-cycle valid pulse.

---
 rtl/options_digit_entry_pkg.sv | 23 ++
 rtl/options_digit_entry_if.sv | 44 ++++
 rtl/options_digit_entry_mul10_add.sv | 29 ++
 rtl/options_digit_entry.sv | 163 ++++++++++++++++
 tb/tb_options_digit_entry.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/options_digit_entry_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : options_digit_entry_pkg
//  Purpose  : Shared types and constants for decimal digit entry / parsing.
//  Revision : 1.0  initial release
// ============================================================================
package options_digit_entry_pkg;

    typedef enum logic [2:0] {
        DE_IDLE    = 3'd0,
        DE_EDIT    = 3'd1,
        DE_CONVERT = 3'd2,
        DE_CLAMP   = 3'd3,
        DE_DONE    = 3'd4
    } DIGIT_ENTRY_STATE;

    // One BCD digit; a digit buffer is a packed array of these, index 0 = LSD.
    typedef logic [3:0] bcd_t;

    localparam logic [3:0] DIGIT_MAX = 4'd9;

endpackage
`default_nettype wire

// File: rtl/options_digit_entry_if.sv
`default_nettype none
// ============================================================================
//  Module   : options_digit_entry_if
//  Purpose  : Key-entry and result bundle between the options menu and the
//             digit-entry block.
//  Revision : 1.0  initial release
// ============================================================================
interface options_digit_entry_if #(
    parameter int W_OUT      = 8,
    parameter int MAX_DIGITS = 2
);
    import options_digit_entry_pkg::*;

    logic                               start;
    logic                               digit_valid;
    logic [3:0]                         digit;
    logic                               backspace;
    logic                               commit;
    logic                               cancel;
    logic [W_OUT-1:0]                   min_value;
    logic [W_OUT-1:0]                   max_value;
    logic                               busy;
    logic                               editing;
    bcd_t [MAX_DIGITS-1:0]              digits_out;
    logic [$clog2(MAX_DIGITS+1)-1:0]    digit_count;
    logic [W_OUT-1:0]                   result;
    logic                               result_valid;
    logic                               cancelled;

    modport master (
        output start, digit_valid, digit, backspace, commit, cancel,
               min_value, max_value,
        input  busy, editing, digits_out, digit_count, result,
               result_valid, cancelled
    );

    modport slave (
        input  start, digit_valid, digit, backspace, commit, cancel,
               min_value, max_value,
        output busy, editing, digits_out, digit_count, result,
               result_valid, cancelled
    );
endinterface
`default_nettype wire

// File: rtl/options_digit_entry_mul10_add.sv
`default_nettype none
// ============================================================================
//  Module   : mul10_add
//  Purpose  : One Horner step of decimal parsing: o_sum = i_acc*10 + i_digit,
//             with a flag when the true value no longer fits W_CHK bits.
//  Revision : 1.0  initial release
// ============================================================================
module mul10_add #(
    parameter int W_ACC = 12,
    parameter int W_CHK = 8
) (
    input  wire logic [W_ACC-1:0] i_acc,
    input  wire logic [3:0]       i_digit,
    output logic      [W_ACC-1:0] o_sum,
    output logic                  o_overflow
);
    localparam int c_FULL_W = W_ACC + 4;

    logic [c_FULL_W-1:0] w_acc_ext;
    logic [c_FULL_W-1:0] w_full;

    // Full-width sum so the overflow test sees bits a W_ACC result would drop.
    assign w_acc_ext  = c_FULL_W'(i_acc);
    assign w_full     = (w_acc_ext << 3) + (w_acc_ext << 1) + c_FULL_W'(i_digit);
    assign o_sum      = w_full[W_ACC-1:0];
    assign o_overflow = |w_full[c_FULL_W-1:W_CHK];

endmodule
`default_nettype wire

// File: rtl/options_digit_entry.sv
`default_nettype none
// ============================================================================
//  Module   : options_digit_entry
//  Purpose  : Collects decimal key entry, converts it MSD-first to binary and
//             returns the value clamped to [min_value, max_value].
//  Revision : 1.0  initial release
// ============================================================================
module options_digit_entry
    import options_digit_entry_pkg::*;
#(
    parameter int W_OUT      = 8,
    parameter int MAX_DIGITS = 2
) (
    input  wire logic              clk,
    input  wire logic              reset,
    options_digit_entry_if.slave   bus
);
    localparam int c_CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int c_IDX_W = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
    localparam int c_ACC_W = W_OUT + 4;

    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(MAX_DIGITS);

    localparam logic [2:0] c_ST_IDLE    = 3'(DE_IDLE);
    localparam logic [2:0] c_ST_EDIT    = 3'(DE_EDIT);
    localparam logic [2:0] c_ST_CONVERT = 3'(DE_CONVERT);
    localparam logic [2:0] c_ST_CLAMP   = 3'(DE_CLAMP);
    localparam logic [2:0] c_ST_DONE    = 3'(DE_DONE);

    logic [2:0]              r_state;
    bcd_t [MAX_DIGITS-1:0]   r_digits;
    logic [c_CNT_W-1:0]      r_count;
    logic [c_IDX_W-1:0]      r_index;
    logic [c_ACC_W-1:0]      r_acc;
    logic                    r_sat;
    logic [W_OUT-1:0]        r_min;
    logic [W_OUT-1:0]        r_max;
    logic [W_OUT-1:0]        r_result;
    logic                    r_cancelled;

    bcd_t [MAX_DIGITS-1:0]   w_digits_shl;
    bcd_t [MAX_DIGITS-1:0]   w_digits_shr;
    logic [c_ACC_W-1:0]      w_step_sum;
    logic                    w_step_ovf;
    logic [W_OUT-1:0]        w_clamped;
    logic                    w_digit_ok;

    mul10_add #(
        .W_ACC (c_ACC_W),
        .W_CHK (W_OUT)
    ) u_mul10_add (
        .i_acc      (r_acc),
        .i_digit    (r_digits[r_index]),
        .o_sum      (w_step_sum),
        .o_overflow (w_step_ovf)
    );

    // Shift-in of a new LSD and backspace removal of the LSD.
    always_comb begin
        w_digits_shl    = '0;
        w_digits_shr    = '0;
        w_digits_shl[0] = bus.digit;
        for (int i = 1; i < MAX_DIGITS; i++) begin
            w_digits_shl[i] = r_digits[i-1];
        end
        for (int i = 0; i < MAX_DIGITS - 1; i++) begin
            w_digits_shr[i] = r_digits[i+1];
        end
    end

    // An inverted range collapses to min; saturation always reports max.
    always_comb begin
        w_clamped = r_acc[W_OUT-1:0];
        if (r_min > r_max) begin
            w_clamped = r_min;
        end else if (r_sat || (r_acc > c_ACC_W'(r_max))) begin
            w_clamped = r_max;
        end else if (r_acc < c_ACC_W'(r_min)) begin
            w_clamped = r_min;
        end
    end

    assign w_digit_ok = (bus.digit <= DIGIT_MAX) && (r_count < c_CNT_FULL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_digits    <= '0;
            r_count     <= '0;
            r_index     <= '0;
            r_acc       <= '0;
            r_sat       <= 1'b0;
            r_min       <= '0;
            r_max       <= '0;
            r_result    <= '0;
            r_cancelled <= 1'b0;
        end else begin
            r_cancelled <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        r_digits <= '0;
                        r_count  <= '0;
                        r_state  <= c_ST_EDIT;
                    end
                end
                c_ST_EDIT: begin
                    if (bus.cancel) begin
                        r_cancelled <= 1'b1;
                        r_state     <= c_ST_IDLE;
                    end else if (bus.commit) begin
                        r_min   <= bus.min_value;
                        r_max   <= bus.max_value;
                        r_acc   <= '0;
                        r_sat   <= 1'b0;
                        r_index <= c_IDX_W'(r_count - 1'b1);
                        r_state <= (r_count == '0) ? c_ST_CLAMP : c_ST_CONVERT;
                    end else if (bus.start) begin
                        r_digits <= '0;
                        r_count  <= '0;
                    end else if (bus.backspace) begin
                        if (r_count != '0) begin
                            r_digits <= w_digits_shr;
                            r_count  <= r_count - 1'b1;
                        end
                    end else if (bus.digit_valid && w_digit_ok) begin
                        r_digits <= w_digits_shl;
                        r_count  <= r_count + 1'b1;
                    end
                end
                c_ST_CONVERT: begin
                    r_acc <= w_step_sum;
                    r_sat <= r_sat | w_step_ovf;
                    if (r_index == '0) begin
                        r_state <= c_ST_CLAMP;
                    end else begin
                        r_index <= r_index - 1'b1;
                    end
                end
                c_ST_CLAMP: begin
                    r_result <= w_clamped;
                    r_state  <= c_ST_DONE;
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy         = (r_state != c_ST_IDLE);
    assign bus.editing      = (r_state == c_ST_EDIT);
    assign bus.digits_out   = r_digits;
    assign bus.digit_count  = r_count;
    assign bus.result       = r_result;
    assign bus.result_valid = (r_state == c_ST_DONE);
    assign bus.cancelled    = r_cancelled;

endmodule
`default_nettype wire

// File: tb/tb_options_digit_entry.sv
`default_nettype none
// ============================================================================
//  Module   : tb_options_digit_entry
//  Purpose  : Self-checking bench: vector table of entry sessions plus
//             hand-written cancel / reset corner cases, scoreboarded results.
//  Revision : 1.0  initial release
// ============================================================================
module tb_options_digit_entry;
    localparam int W_OUT      = 8;
    localparam int MAX_DIGITS = 2;
    localparam int BS         = 16;
    localparam int NVEC       = 9;

    typedef struct {
        int               nops;
        logic [5:0][4:0]  ops;
        logic [7:0]       min_v;
        logic [7:0]       max_v;
        logic [7:0]       exp_res;
        int               exp_cnt;
        logic [7:0]       exp_dig;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    logic [7:0] sb[$];
    logic [7:0] last_result;
    vec_t vecs [NVEC];

    options_digit_entry_if #(.W_OUT(W_OUT), .MAX_DIGITS(MAX_DIGITS)) ifc ();

    options_digit_entry #(.W_OUT(W_OUT), .MAX_DIGITS(MAX_DIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input int n, input int o0, input int o1, input int o2,
                                input int o3, input int mn, input int mx, input int res,
                                input int cnt, input int dig);
        vec_t v;
        v.nops    = n;
        v.ops     = '0;
        v.ops[0]  = 5'(o0);
        v.ops[1]  = 5'(o1);
        v.ops[2]  = 5'(o2);
        v.ops[3]  = 5'(o3);
        v.min_v   = 8'(mn);
        v.max_v   = 8'(mx);
        v.exp_res = 8'(res);
        v.exp_cnt = cnt;
        v.exp_dig = 8'(dig);
        return v;
    endfunction

    // Scoreboard: every result_valid must match the oldest pending expectation.
    always @(negedge clk) begin
        if (ifc.result_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_result_valid: got 1 required 0");
            end else begin
                chk("result", 32'(ifc.result), 32'(sb.pop_front()));
            end
        end
    end

    task automatic enter_keys(input vec_t v);
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        for (int j = 0; j < v.nops; j++) begin
            if (int'(v.ops[j]) == BS) ifc.backspace = 1'b1;
            else begin
                ifc.digit_valid = 1'b1;
                ifc.digit       = v.ops[j][3:0];
            end
            tick();
            ifc.backspace   = 1'b0;
            ifc.digit_valid = 1'b0;
        end
    endtask

    task automatic run_session(input vec_t v, input string nm);
        int lat;
        enter_keys(v);
        chk({nm, "_count"},   32'(ifc.digit_count), 32'(v.exp_cnt));
        chk({nm, "_digits"},  32'(ifc.digits_out),  32'(v.exp_dig));
        chk({nm, "_editing"}, 32'(ifc.editing),     32'd1);
        ifc.min_value = v.min_v;
        ifc.max_value = v.max_v;
        ifc.commit    = 1'b1;
        sb.push_back(v.exp_res);
        last_result = v.exp_res;
        tick();
        ifc.commit    = 1'b0;
        ifc.min_value = 8'($urandom);
        ifc.max_value = 8'($urandom);
        lat = 1;
        while (!ifc.result_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({nm, "_latency"}, 32'(lat), 32'(v.exp_cnt + 2));
        tick();
        chk({nm, "_pulse_end"}, 32'({ifc.result_valid, ifc.busy}), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        last_result = '0;
        ifc.start = 0; ifc.digit_valid = 0; ifc.digit = 0; ifc.backspace = 0;
        ifc.commit = 0; ifc.cancel = 0; ifc.min_value = 0; ifc.max_value = 0;

        vecs[0] = mk(2, 1, 5, 0, 0,    1,  20,  15, 2, 8'h15);
        vecs[1] = mk(3, 9, 9, 7, 0,    0,  20,  20, 2, 8'h99);
        vecs[2] = mk(4, 4, BS, BS, 7,  3,  21,   7, 1, 8'h07);
        vecs[3] = mk(0, 0, 0, 0, 0,    3,  50,   3, 0, 8'h00);
        vecs[4] = mk(2, 10, 3, 0, 0,   0,  99,   3, 1, 8'h03);
        vecs[5] = mk(2, 9, 9, 0, 0,    0, 255,  99, 2, 8'h99);
        vecs[6] = mk(1, 5, 0, 0, 0,   10,  20,  10, 1, 8'h05);
        vecs[7] = mk(1, 7, 0, 0, 0,    9,   4,   9, 1, 8'h07);
        vecs[8] = mk(3, 2, 5, BS, 0,   0, 255,   2, 1, 8'h02);

        reset = 1'b1;
        tick();
        tick();
        chk("rst_busy",    32'(ifc.busy),         0);
        chk("rst_editing", 32'(ifc.editing),      0);
        chk("rst_digits",  32'(ifc.digits_out),   0);
        chk("rst_count",   32'(ifc.digit_count),  0);
        chk("rst_result",  32'(ifc.result),       0);
        chk("rst_valid",   32'(ifc.result_valid), 0);
        chk("rst_cancel",  32'(ifc.cancelled),    0);
        reset = 1'b0;
        tick();

        for (int v = 0; v < NVEC; v++) begin
            run_session(vecs[v], $sformatf("vec%0d", v));
        end

        // start while editing re-clears the buffer
        enter_keys(mk(1, 3, 0, 0, 0, 0, 0, 0, 1, 8'h03));
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        chk("restart_count",  32'(ifc.digit_count), 0);
        chk("restart_digits", 32'(ifc.digits_out),  0);

        // digit 0xA ignored; commit+cancel together: cancel wins
        ifc.digit_valid = 1'b1;
        ifc.digit       = 4'hA;
        tick();
        ifc.digit_valid = 1'b0;
        chk("bad_digit_count", 32'(ifc.digit_count), 0);
        ifc.digit_valid = 1'b1;
        ifc.digit       = 4'd2;
        tick();
        ifc.digit_valid = 1'b0;
        ifc.commit = 1'b1;
        ifc.cancel = 1'b1;
        ifc.max_value = 8'd200;
        tick();
        ifc.commit = 1'b0;
        ifc.cancel = 1'b0;
        chk("cancel_pulse",  32'(ifc.cancelled),  1);
        chk("cancel_busy",   32'(ifc.busy),       0);
        chk("cancel_digits", 32'(ifc.digits_out), 32'h02);
        chk("cancel_result", 32'(ifc.result),     32'(last_result));
        tick();
        chk("cancel_pulse_end", 32'(ifc.cancelled), 0);
        repeat (4) tick();

        // asynchronous reset in the middle of a conversion
        enter_keys(mk(2, 2, 5, 0, 0, 0, 0, 0, 2, 8'h25));
        ifc.max_value = 8'd99;
        ifc.commit = 1'b1;
        tick();
        ifc.commit = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("amid_busy",   32'(ifc.busy),         0);
        chk("amid_digits", 32'(ifc.digits_out),   0);
        chk("amid_count",  32'(ifc.digit_count),  0);
        chk("amid_result", 32'(ifc.result),       0);
        chk("amid_valid",  32'(ifc.result_valid), 0);
        tick();
        reset = 1'b0;
        repeat (6) tick();
        run_session(mk(2, 1, 2, 0, 0, 0, 255, 12, 2, 8'h12), "post_reset");

        repeat (3) tick();
        chk("sb_empty", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
